clk_profiler: RTL and testbench

CLK_PROFILER -- requirements
Module: clk_profiler

---
 rtl/clk_profiler.sv | 108 ++++++++++
 tb/tb_clk_profiler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clk_profiler.sv
// clk_profiler: measures phase, high time, low time and period of an asynchronous input
module clk_profiler #(
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] ton_cnt,
  output logic [CNT_W-1:0] toff_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t              state_q, state_d;
  logic [SYNC_STG-1:0] sync_q;
  logic                hist_q;
  logic [CNT_W:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]    phase_q, phase_d, ton_q, ton_d;
  logic [CNT_W-1:0]    phase_o_q, ton_o_q, toff_o_q;
  logic [CNT_W:0]      period_q;
  logic                mv_q, to_q, pub, tmo, rise, fall, expired;
  logic [CNT_W-1:0]    el;
  assign rise    = sync_q[SYNC_STG-1] & ~hist_q;
  assign fall    = ~sync_q[SYNC_STG-1] & hist_q;
  assign el      = cnt_q[CNT_W-1:0];
  // cnt_q holds edges elapsed since the interval origin; its top bit means no event in range
  assign expired = cnt_q[CNT_W];
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q + 1'b1;
    phase_d = phase_q;
    ton_d   = ton_q;
    pub     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: if (start && !mv_q && !to_q) begin
        state_d = WAIT_RISE;
        cnt_d   = (CNT_W+1)'(1);
      end
      WAIT_RISE: if (expired) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end else if (rise) begin
        phase_d = el;
        cnt_d   = (CNT_W+1)'(1);
        state_d = MEAS_HIGH;
      end
      MEAS_HIGH: if (expired) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end else if (fall) begin
        ton_d   = el;
        cnt_d   = (CNT_W+1)'(1);
        state_d = MEAS_LOW;
      end
      MEAS_LOW: if (expired) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end else if (rise) begin
        pub     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      ton_q     <= '0;
      phase_o_q <= '0;
      ton_o_q   <= '0;
      toff_o_q  <= '0;
      period_q  <= '0;
      mv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STG-2:0], sig_in};
      hist_q  <= sync_q[SYNC_STG-1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ton_q   <= ton_d;
      mv_q    <= pub;
      to_q    <= tmo;
      if (pub) begin
        phase_o_q <= phase_q;
        ton_o_q   <= ton_q;
        toff_o_q  <= el;
        period_q  <= {1'b0, ton_q} + {1'b0, el};
      end
    end
  end
  assign phase_cnt  = phase_o_q;
  assign ton_cnt    = ton_o_q;
  assign toff_cnt   = toff_o_q;
  assign period_cnt = period_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_clk_profiler.sv
// tb_clk_profiler: random and directed stimulus checked against an event-timestamp model
module tb_clk_profiler;
  localparam int W  = 4;
  localparam int SS = 2;
  logic clk = 0, rst = 1, start = 0, sig_in = 0;
  logic [W-1:0] phase_cnt, ton_cnt, toff_cnt;
  logic [W:0]   period_cnt;
  logic         meas_valid, busy, timeout;
  int n_chk = 0, n_err = 0;
  clk_profiler #(.CNT_W(W), .SYNC_STG(SS)) dut (
    .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
    .phase_cnt(phase_cnt), .ton_cnt(ton_cnt), .toff_cnt(toff_cnt),
    .period_cnt(period_cnt), .meas_valid(meas_valid), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  // model: h[j] is the sig_in sample taken j+1 edges ago; events are timestamped by edge number
  bit h[0:SS];
  int edge_n = 0, origin = 0, stage = 0, m_ph = 0, m_tn = 0, el;
  bit chk_en = 0, m_rise, m_fall, pmv, pto;
  logic [W-1:0] e_ph = 0, e_tn = 0, e_tf = 0;
  logic [W:0]   e_pd = 0;
  bit e_mv = 0, e_to = 0;
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      chk_en = 1;
      stage = 0; e_ph = 0; e_tn = 0; e_tf = 0; e_pd = 0; e_mv = 0; e_to = 0;
      for (int j = 0; j <= SS; j++) h[j] = 0;
    end else begin
      m_rise = h[SS-1] && !h[SS];
      m_fall = !h[SS-1] && h[SS];
      el = edge_n - origin;
      pmv = e_mv; pto = e_to;
      e_mv = 0; e_to = 0;
      if (stage == 0) begin
        if (start && !pmv && !pto) begin stage = 1; origin = edge_n; end
      end else if (el >= (1 << W)) begin
        e_to = 1; stage = 0;
      end else if (stage == 1 && m_rise) begin
        m_ph = el; origin = edge_n; stage = 2;
      end else if (stage == 2 && m_fall) begin
        m_tn = el; origin = edge_n; stage = 3;
      end else if (stage == 3 && m_rise) begin
        e_ph = m_ph[W-1:0]; e_tn = m_tn[W-1:0]; e_tf = el[W-1:0];
        e_pd = (W+1)'(m_tn + el); e_mv = 1; stage = 0;
      end
      for (int j = SS; j > 0; j--) h[j] = h[j-1];
      h[0] = sig_in;
    end
  end
  always @(negedge clk) if (chk_en) begin
    n_chk++;
    if ({phase_cnt, ton_cnt, toff_cnt, period_cnt, meas_valid, timeout, busy} !==
        {e_ph, e_tn, e_tf, e_pd, e_mv, e_to, stage != 0}) begin
      n_err++;
      $display("FAIL model t=%0t got ph=%0d ton=%0d toff=%0d per=%0d mv=%b to=%b busy=%b exp ph=%0d ton=%0d toff=%0d per=%0d mv=%b to=%b busy=%b",
               $time, phase_cnt, ton_cnt, toff_cnt, period_cnt, meas_valid, timeout, busy,
               e_ph, e_tn, e_tf, e_pd, e_mv, e_to, stage != 0);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drv(input bit st, input bit s);
    @(negedge clk);
    start = st;
    sig_in = s;
  endtask
  task automatic settle();
    repeat (6) drv(0, 0);
  endtask
  task automatic basic(input string nm);
    drv(1, 0);
    for (int k = 1; k <= 15; k++) drv(0, (k >= 5 && k <= 7) || k >= 13);
    chk({nm, "_mv_early"}, int'(meas_valid), 0);
    @(negedge clk);
    chk({nm, "_mv"}, int'(meas_valid), 1);
    chk({nm, "_phase"}, int'(phase_cnt), 7);
    chk({nm, "_ton"}, int'(ton_cnt), 3);
    chk({nm, "_toff"}, int'(toff_cnt), 5);
    chk({nm, "_period"}, int'(period_cnt), 8);
    settle();
  endtask
  int mv_n, run;
  initial begin
    repeat (2) drv(1, 1);
    rst = 0;
    start = 0; sig_in = 0;
    @(negedge clk);
    chk("reset_out", int'({phase_cnt, ton_cnt, toff_cnt, period_cnt, meas_valid, timeout, busy}), 0);
    settle();
    basic("basic");
    repeat (4) drv(0, 1);
    drv(1, 1);
    for (int k = 1; k <= 16; k++) drv(0, k < 2 || (k >= 6 && k <= 9) || k >= 14);
    @(negedge clk);
    chk("hi_start_mv", int'(meas_valid), 1);
    chk("hi_start_phase", int'(phase_cnt), 8);
    chk("hi_start_ton", int'(ton_cnt), 4);
    chk("hi_start_period", int'(period_cnt), 8);
    settle();
    drv(1, 0);
    for (int k = 1; k <= 16; k++) drv(0, 0);
    chk("to_early", int'(timeout), 0);
    chk("to_busy_before", int'(busy), 1);
    @(negedge clk);
    chk("to_pulse", int'(timeout), 1);
    chk("to_busy_after", int'(busy), 0);
    chk("to_keep_phase", int'(phase_cnt), 8);
    chk("to_keep_period", int'(period_cnt), 8);
    @(negedge clk);
    chk("to_one_cycle", int'(timeout), 0);
    settle();
    drv(1, 0);
    for (int k = 1; k <= 33; k++) drv(0, k <= 15 || k >= 31);
    @(negedge clk);
    chk("max_mv", int'(meas_valid), 1);
    chk("max_ton", int'(ton_cnt), 15);
    chk("max_toff", int'(toff_cnt), 15);
    chk("max_period", int'(period_cnt), 30);
    chk("max_no_to", int'(timeout), 0);
    settle();
    mv_n = 0;
    drv(1, 0);
    for (int k = 1; k <= 40; k++) begin
      drv(k == 8 || k == 16, (k >= 5 && k <= 7) || (k >= 13 && k <= 17) || (k >= 21 && k <= 23) || k >= 27);
      mv_n += int'(meas_valid);
    end
    chk("busy_start_mv_count", mv_n, 1);
    chk("busy_start_phase", int'(phase_cnt), 7);
    chk("busy_start_toff", int'(toff_cnt), 5);
    settle();
    mv_n = 0;
    drv(1, 0);
    for (int k = 1; k <= 25; k++) begin
      drv(0, (k >= 5 && k <= 7) || k >= 13);
      rst = (k == 12);
      mv_n += int'(meas_valid);
    end
    chk("rst_no_mv", mv_n, 0);
    chk("rst_out_zero", int'({phase_cnt, ton_cnt, toff_cnt, period_cnt, busy}), 0);
    settle();
    basic("after_rst");
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (run == 0) begin
        sig_in = ~sig_in;
        run = $urandom_range(1, 18);
      end
      run--;
    end
    rst = 0;
    start = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
